mapa_arbiter: RTL and testbench

//  Sole owner of the single-port tile-map RAM (MAPA_WIDTH x MAPA_HEIGHT cells, 2 bits each).

---
 rtl/mapa_arbiter.sv | 134 +++++++++++++
 tb/tb_mapa_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mapa_arbiter.sv
// mapa_arbiter: owns the tile-map RAM, arbitrates renderer/update/fruta access and runs the clear sweep.
// Every access is registered onto the RAM port one cycle after grant; read data returns three cycles after grant.
module mapa_arbiter #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int ADDR_W      = 11,
  parameter int AGE_MAX     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              rend_req,
  input  logic [9:0]        rend_x,
  input  logic [9:0]        rend_y,
  output logic [1:0]        rend_rdata,
  output logic              rend_rvalid,
  input  logic              upd_req,
  input  logic              upd_we,
  input  logic [9:0]        upd_x,
  input  logic [9:0]        upd_y,
  input  logic [1:0]        upd_wdata,
  output logic              upd_ack,
  output logic [1:0]        upd_rdata,
  output logic              upd_rvalid,
  input  logic              fru_req,
  input  logic [9:0]        fru_x,
  input  logic [9:0]        fru_y,
  output logic              fru_ack,
  output logic [1:0]        fru_rdata,
  output logic              fru_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [1:0]        ram_wdata,
  input  logic [1:0]        ram_rdata
);
  localparam int CELLS = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d, ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d, upd_ack_q, upd_ack_d, fru_ack_q, fru_ack_d;
  logic [1:0]        ram_wdata_q, ram_wdata_d;
  logic [AGE_W-1:0]  age_q, age_d;
  // read-owner bits per pipeline stage, ordered {fru, upd, rend}
  logic [2:0]        s1_q, s1_d, s2_q, s2_d, rv_q, rv_d;
  logic              s1_oor_q, s1_oor_d, s2_oor_q, s2_oor_d;
  logic [2:0][1:0]   rdat_q, rdat_d;
  logic              g_rend, g_clr, g_upd, g_fru, idle_free, age_hi, rng, acc, wr;
  logic [9:0]        sx, sy;
  logic [1:0]        rdv;

  always_comb begin
    age_hi      = age_q == AGE_W'(AGE_MAX);
    idle_free   = !rend_req && state_q == IDLE;
    g_rend      = rend_req;
    g_clr       = !rend_req && state_q == CLEAR;
    g_fru       = idle_free && fru_req && (age_hi || !upd_req);
    g_upd       = idle_free && upd_req && !g_fru;
    sx          = g_rend ? rend_x : g_upd ? upd_x : fru_x;
    sy          = g_rend ? rend_y : g_upd ? upd_y : fru_y;
    rng         = 32'(sx) < MAPA_WIDTH && 32'(sy) < MAPA_HEIGHT;
    acc         = (g_rend || g_upd || g_fru) && rng;
    wr          = g_upd && upd_we && rng;
    ram_addr_d  = g_clr ? p_q : acc ? ADDR_W'(sy) * ADDR_W'(MAPA_WIDTH) + ADDR_W'(sx) : ram_addr_q;
    ram_we_d    = g_clr || wr;
    ram_wdata_d = wr ? upd_wdata : 2'b00;
    upd_ack_d   = g_upd;
    fru_ack_d   = g_fru;
    age_d       = (!fru_req || g_fru) ? '0 : age_hi ? age_q : age_q + 1'b1;
    s1_d        = {g_fru, g_upd && !upd_we, g_rend};
    s1_oor_d    = !rng;
    s2_d        = s1_q;
    s2_oor_d    = s1_oor_q;
    rv_d        = s2_q;
    // out-of-range reads never touched the RAM and report an obstacle
    rdv         = s2_oor_q ? 2'b11 : ram_rdata;
    rdat_d[0]   = s2_q[0] ? rdv : 2'b00;
    rdat_d[1]   = s2_q[1] ? rdv : 2'b00;
    rdat_d[2]   = s2_q[2] ? rdv : 2'b00;
    state_d     = state_q == IDLE ? (clear_start ? CLEAR : IDLE)
                                  : (g_clr && p_q == ADDR_W'(CELLS - 1) ? IDLE : CLEAR);
    p_d         = state_q == IDLE ? '0 : g_clr ? p_q + 1'b1 : p_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      p_q         <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 2'b00;
      upd_ack_q   <= 1'b0;
      fru_ack_q   <= 1'b0;
      age_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      rv_q        <= '0;
      s1_oor_q    <= 1'b0;
      s2_oor_q    <= 1'b0;
      rdat_q      <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      upd_ack_q   <= upd_ack_d;
      fru_ack_q   <= fru_ack_d;
      age_q       <= age_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rv_q        <= rv_d;
      s1_oor_q    <= s1_oor_d;
      s2_oor_q    <= s2_oor_d;
      rdat_q      <= rdat_d;
    end
  end

  assign clear_busy  = state_q == CLEAR;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign upd_ack     = upd_ack_q;
  assign fru_ack     = fru_ack_q;
  assign rend_rvalid = rv_q[0];
  assign upd_rvalid  = rv_q[1];
  assign fru_rvalid  = rv_q[2];
  assign rend_rdata  = rdat_q[0];
  assign upd_rdata   = rdat_q[1];
  assign fru_rdata   = rdat_q[2];
endmodule

// File: tb/tb_mapa_arbiter.sv
// tb_mapa_arbiter: directed and randomized checks of mapa_arbiter against a transaction-level map model.
// The model resolves each cycle's winner from the priority rules and keeps its own copy of the map contents.
module tb_mapa_arbiter;
  localparam int W = 40, H = 30, AGE = 8;

  logic        clk = 0, reset = 0, clear_start = 0;
  logic        rend_req = 0, upd_req = 0, upd_we = 0, fru_req = 0;
  logic [9:0]  rend_x = 0, rend_y = 0, upd_x = 0, upd_y = 0, fru_x = 0, fru_y = 0;
  logic [1:0]  upd_wdata = 0;
  logic        clear_busy, rend_rvalid, upd_ack, upd_rvalid, fru_ack, fru_rvalid, ram_we;
  logic [1:0]  rend_rdata, upd_rdata, fru_rdata, ram_wdata, ram_rdata;
  logic [10:0] ram_addr;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mapa_arbiter dut (
    .clk(clk), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
    .rend_req(rend_req), .rend_x(rend_x), .rend_y(rend_y), .rend_rdata(rend_rdata), .rend_rvalid(rend_rvalid),
    .upd_req(upd_req), .upd_we(upd_we), .upd_x(upd_x), .upd_y(upd_y), .upd_wdata(upd_wdata),
    .upd_ack(upd_ack), .upd_rdata(upd_rdata), .upd_rvalid(upd_rvalid),
    .fru_req(fru_req), .fru_x(fru_x), .fru_y(fru_y), .fru_ack(fru_ack), .fru_rdata(fru_rdata), .fru_rvalid(fru_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // model state: what the outputs must show after each clock edge
  bit          m_busy = 0, m_we = 0, m_uack = 0, m_fack = 0;
  int          m_p = 0, m_age = 0, m_addr = 0;
  logic [1:0]  m_wd = 0;
  logic [8:0]  d1 = 0, d2 = 0, dq = 0;
  logic [1:0]  ram [2048];
  logic [1:0]  mmem [W*H];
  logic [25:0] dut_vec, exp_vec;

  assign dut_vec = {clear_busy, rend_rvalid, rend_rdata, upd_ack, upd_rvalid, upd_rdata,
                    fru_ack, fru_rvalid, fru_rdata, ram_we, ram_wdata, ram_addr};
  assign exp_vec = {m_busy, dq[8], dq[7:6], m_uack, dq[5], dq[4:3], m_fack, dq[2], dq[1:0], m_we, m_wd, 11'(m_addr)};

  task automatic model_step();
    int g, x, y;
    bit old_busy;
    logic [1:0] d;
    logic [8:0] slot;
    if (!reset) begin
      m_busy = 0; m_p = 0; m_age = 0; m_addr = 0; m_we = 0; m_wd = 0; m_uack = 0; m_fack = 0;
      d1 = 0; d2 = 0; dq = 0;
      return;
    end
    old_busy = m_busy; slot = 0; d = 0;
    g = rend_req ? 1 : m_busy ? 2 : (fru_req && (m_age == AGE || !upd_req)) ? 4 : upd_req ? 3 : 0;
    m_age = (!fru_req || g == 4) ? 0 : (m_age < AGE ? m_age + 1 : AGE);
    m_uack = g == 3; m_fack = g == 4; m_we = 0; m_wd = 0;
    if (g == 2) begin
      m_addr = m_p; m_we = 1; mmem[m_p] = 2'b00;
      if (m_p == W*H-1) m_busy = 0;
      m_p++;
    end else if (g != 0) begin
      x = g == 1 ? int'(rend_x) : g == 3 ? int'(upd_x) : int'(fru_x);
      y = g == 1 ? int'(rend_y) : g == 3 ? int'(upd_y) : int'(fru_y);
      if (x < W && y < H) begin
        m_addr = y*W + x;
        if (g == 3 && upd_we) begin m_we = 1; m_wd = upd_wdata; mmem[m_addr] = upd_wdata; end
        d = mmem[m_addr];
      end else d = 2'b11;
      if (g == 1) slot[8:6] = {1'b1, d};
      else if (g == 3 && !upd_we) slot[5:3] = {1'b1, d};
      else if (g == 4) slot[2:0] = {1'b1, d};
    end
    if (clear_start && !old_busy) begin m_busy = 1; m_p = 0; end
    dq = d2; d2 = d1; d1 = slot;
  endtask

  // synchronous RAM behind the DUT plus the model, advanced on the same edge
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 2'($urandom);
    for (int i = 0; i < W*H; i++) mmem[i] = ram[i];
    forever begin
      @(posedge clk);
      ram_rdata <= ram[ram_addr];
      if (ram_we) ram[ram_addr] = ram_wdata;
      model_step();
    end
  end

  function automatic logic [9:0] rx(input int lim);
    return $urandom_range(0, 5) == 0 ? 10'(lim + $urandom_range(0, 3)) : 10'($urandom_range(0, 7));
  endfunction

  task automatic idle_in();
    rend_req = 0; upd_req = 0; fru_req = 0; clear_start = 0; upd_we = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; idle_in(); end
  endtask

  task automatic test_reset();
    reset = 0; idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec); end
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      reset = k != 6; clear_start = k == 0; rend_req = k >= 3 && k <= 6; rend_x = 5; rend_y = 5;
      @(negedge clk);
      n_chk++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL reset_model k=%0d: got %h want %h", k, dut_vec, exp_vec); end
      if (k == 3) begin n_chk++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL reset_sweep_busy: got %b want 1", clear_busy); end end
      if (k == 7) begin n_chk++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_mid_sweep: got %h want 0", dut_vec); end end
      if (k >= 7) begin
        n_chk++;
        if ({rend_rvalid, upd_rvalid, fru_rvalid} !== 3'b000) begin
          n_fail++; $display("FAIL reset_stray_rvalid k=%0d: got %b want 000", k, {rend_rvalid, upd_rvalid, fru_rvalid});
        end
      end
    end
    idle_in();
  endtask

  task automatic test_render();
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      rend_req = 1; rend_x = 39; rend_y = 29;
      upd_req = 1; upd_we = 1; upd_x = 1; upd_y = 1; upd_wdata = 2;
      @(negedge clk);
      n_chk++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL render_model k=%0d: got %h want %h", k, dut_vec, exp_vec); end
      n_chk++; if (upd_ack !== 1'b0) begin n_fail++; $display("FAIL render_upd_starved k=%0d: got %b want 0", k, upd_ack); end
      if (k >= 1) begin n_chk++; if (ram_addr !== 11'd1199 || ram_we !== 1'b0) begin n_fail++; $display("FAIL render_addr k=%0d: got %0d/%b want 1199/0", k, ram_addr, ram_we); end end
      if (k >= 3) begin n_chk++; if (rend_rvalid !== 1'b1) begin n_fail++; $display("FAIL render_rvalid k=%0d: got %b want 1", k, rend_rvalid); end end
    end
    idle_in();
  endtask

  task automatic test_write();
    settle(4);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      upd_req = k == 0; upd_we = 1; upd_x = 10; upd_y = 10; upd_wdata = 2'b01;
      fru_req = k == 1; fru_x = 10; fru_y = 10;
      @(negedge clk);
      n_chk++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL write_model k=%0d: got %h want %h", k, dut_vec, exp_vec); end
      if (k == 1) begin n_chk++; if ({ram_addr, ram_we, ram_wdata, upd_ack} !== {11'd410, 1'b1, 2'b01, 1'b1}) begin n_fail++; $display("FAIL write_port: got %0d/%b/%b/%b want 410/1/01/1", ram_addr, ram_we, ram_wdata, upd_ack); end end
      if (k == 2) begin n_chk++; if ({fru_ack, ram_we, ram_addr} !== {1'b1, 1'b0, 11'd410}) begin n_fail++; $display("FAIL write_fru_grant: got %b/%b/%0d want 1/0/410", fru_ack, ram_we, ram_addr); end end
      if (k == 4) begin n_chk++; if ({fru_rvalid, fru_rdata} !== 3'b101) begin n_fail++; $display("FAIL write_readback: got %b/%b want 1/01", fru_rvalid, fru_rdata); end end
    end
    idle_in();
  endtask

  task automatic test_oor();
    logic [10:0] a0 = 0;
    settle(4);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      fru_req = k == 0; fru_x = 40; fru_y = 5;
      upd_req = k == 1; upd_we = 1; upd_x = 3; upd_y = 30; upd_wdata = 2'b10;
      @(negedge clk);
      n_chk++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL oor_model k=%0d: got %h want %h", k, dut_vec, exp_vec); end
      if (k == 0) a0 = ram_addr;
      if (k == 1) begin n_chk++; if ({fru_ack, ram_we, ram_addr} !== {1'b1, 1'b0, a0}) begin n_fail++; $display("FAIL oor_fru_grant: got %b/%b/%0d want 1/0/%0d", fru_ack, ram_we, ram_addr, a0); end end
      if (k == 2) begin n_chk++; if ({upd_ack, ram_we, ram_addr} !== {1'b1, 1'b0, a0}) begin n_fail++; $display("FAIL oor_write_dropped: got %b/%b/%0d want 1/0/%0d", upd_ack, ram_we, ram_addr, a0); end end
      if (k == 3) begin n_chk++; if ({fru_rvalid, fru_rdata} !== 3'b111) begin n_fail++; $display("FAIL oor_obstacle: got %b/%b want 1/11", fru_rvalid, fru_rdata); end end
    end
    idle_in();
  endtask

  task automatic test_aging();
    int first_f = -1, n_u = 0;
    settle(4);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      upd_req = 1; upd_we = 0; upd_x = 2; upd_y = 2;
      fru_req = first_f < 0; fru_x = 4; fru_y = 4;
      @(negedge clk);
      n_chk++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL aging_model k=%0d: got %h want %h", k, dut_vec, exp_vec); end
      if (first_f < 0 && upd_ack) n_u++;
      if (first_f < 0 && fru_ack) first_f = k;
    end
    n_chk++; if (first_f != 9) begin n_fail++; $display("FAIL aging_fru_ack_cycle: got %0d want 9", first_f); end
    n_chk++; if (n_u != 8) begin n_fail++; $display("FAIL aging_upd_wins: got %0d want 8", n_u); end
    idle_in();
  endtask

  task automatic test_clear(input int burst);
    int k = 0, busy_n = 0, exp_a = 0, bad = 0;
    bit done = 0;
    settle(4);
    while (!done && k < 1400) begin
      @(posedge clk); #1;
      clear_start = k == 0; upd_req = 1; upd_we = 0; upd_x = 6; upd_y = 6;
      rend_req = k >= 100 && k < 100 + burst; rend_x = 0; rend_y = 0;
      @(negedge clk);
      n_chk++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL clear_model k=%0d: got %h want %h", k, dut_vec, exp_vec); end
      if (clear_busy) busy_n++;
      if (ram_we) begin
        n_chk++; if (ram_addr !== 11'(exp_a) || ram_wdata !== 2'b00) begin n_fail++; $display("FAIL clear_write k=%0d: got %0d/%b want %0d/00", k, ram_addr, ram_wdata, exp_a); end
        exp_a++;
      end
      if (k == 1) begin n_chk++; if (upd_ack !== 1'b1) begin n_fail++; $display("FAIL clear_same_cycle_upd: got %b want 1", upd_ack); end end
      if (k > 1 && clear_busy && upd_ack) bad++;
      done = k > 1 && !clear_busy;
      k++;
    end
    n_chk++; if (busy_n != 1200 + burst) begin n_fail++; $display("FAIL clear_busy_len: got %0d want %0d", busy_n, 1200 + burst); end
    n_chk++; if (exp_a != 1200) begin n_fail++; $display("FAIL clear_write_count: got %0d want 1200", exp_a); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL clear_ack_while_busy: got %0d want 0", bad); end
    idle_in();
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reset = $urandom_range(0, 999) >= 3;
      clear_start = $urandom_range(0, 999) < 2;
      rend_req = $urandom_range(0, 99) < 30; rend_x = rx(40); rend_y = rx(30);
      if (!upd_req || upd_ack) begin
        upd_req = 1'($urandom); upd_we = 1'($urandom); upd_x = rx(40); upd_y = rx(30); upd_wdata = 2'($urandom);
      end
      if (!fru_req || fru_ack) begin
        fru_req = 1'($urandom); fru_x = rx(40); fru_y = rx(30);
      end
      @(negedge clk);
      n_chk++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL random_model k=%0d: got %h want %h", k, dut_vec, exp_vec); end
    end
    reset = 1; idle_in();
  endtask

  initial begin
    test_reset();
    test_render();
    test_write();
    test_oor();
    test_aging();
    test_clear(0);
    test_clear(5);
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
